muldiv_ctrl: RTL and testbench

Sequencer for the multi-cycle multiplier and divider IPs in the EX stage. Accepts a mul/div request from the EX control word, issues a single-cycle start pulse to the selected unit, and holds the pipeline via `busy` until the unit reports done. It then presents the latched HI/LO result for one pipeline advance. Flushes abandon an in-flight operation safely by draining the unit.

---
 rtl/muldiv_ctrl_pkg.sv | 28 ++
 rtl/muldiv_ctrl.sv | 153 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the EX-stage mul/div sequencer.
package muldiv_ctrl_pkg;

  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned DW          = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } muldiv_state_t;

  typedef enum logic [1:0] {
    MODE_MULT = 2'b00,
    MODE_MADD = 2'b01,
    MODE_MSUB = 2'b10,
    MODE_MUL  = 2'b11
  } mul_mode_t;

  // HI/LO result pair as returned by either arithmetic unit.
  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle multiplier/divider: start pulse, pipeline
// hold while the unit works, HI/LO capture, and safe drain on flush.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_mul,
  input  logic          req_div,
  input  logic          req_sign,
  input  logic [1:0]    req_mode,
  input  logic          flush,
  input  logic          stall_in,
  output logic          mul_start,
  output logic          div_start,
  output logic          op_sign,
  output logic [1:0]    op_mode,
  input  logic          mul_done,
  input  logic          div_done,
  input  logic [DW-1:0] mul_hi,
  input  logic [DW-1:0] mul_lo,
  input  logic [DW-1:0] div_hi,
  input  logic [DW-1:0] div_lo,
  output logic          busy,
  output logic          res_valid,
  output logic          res_is_div,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out,
  output logic          err
);

  muldiv_state_t r_state;
  muldiv_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_mul_start;
  logic          r_div_start;
  logic          r_op_sign;
  logic [1:0]    r_op_mode;
  logic          r_op_div;
  logic          r_res_is_div;
  hilo_t         r_res;
  hilo_t         w_res_sel;
  logic          w_accept;
  logic          w_accept_div;
  logic          w_latch;
  logic          w_busy;
  logic          w_err;
  logic          w_unit_done;
  logic          w_timeout;

  // Next-state, hold request and error decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_accept_div = 1'b0;
    w_latch      = 1'b0;
    w_busy       = 1'b0;
    w_err        = 1'b0;
    w_unit_done  = r_op_div ? div_done : mul_done;
    w_timeout    = (r_cnt == CW'(TIMEOUT));
    w_res_sel    = r_op_div ? {div_hi, div_lo} : {mul_hi, mul_lo};
    case (r_state)
      ST_IDLE: begin
        if ((req_mul || req_div) && !flush) begin
          w_busy       = 1'b1;
          w_accept     = 1'b1;
          w_accept_div = !req_mul;
          w_err        = req_mul && req_div;
          w_cnt_nxt    = '0;
          w_state_nxt  = req_mul ? ST_MUL_WAIT : ST_DIV_WAIT;
        end
      end
      ST_MUL_WAIT, ST_DIV_WAIT: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_unit_done) begin
          // A flush arriving with done discards the result outright.
          w_latch     = !flush;
          w_state_nxt = flush ? ST_IDLE : ST_DONE;
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_unit_done) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (flush || !stall_in) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, wait counter, start pulses, operand attributes and result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mul_start  <= 1'b0;
      r_div_start  <= 1'b0;
      r_op_sign    <= 1'b0;
      r_op_mode    <= 2'b00;
      r_op_div     <= 1'b0;
      r_res_is_div <= 1'b0;
      r_res        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mul_start <= w_accept && !w_accept_div;
      r_div_start <= w_accept && w_accept_div;
      if (w_accept) begin
        r_op_sign <= req_sign;
        r_op_mode <= req_mode;
        r_op_div  <= w_accept_div;
      end
      if (w_latch) begin
        r_res        <= w_res_sel;
        r_res_is_div <= r_op_div;
      end
    end
  end

  assign mul_start  = r_mul_start;
  assign div_start  = r_div_start;
  assign op_sign    = r_op_sign;
  assign op_mode    = r_op_mode;
  assign busy       = w_busy;
  assign err        = w_err;
  assign res_valid  = (r_state == ST_DONE);
  assign res_is_div = r_res_is_div;
  assign hi_out     = r_res.hi;
  assign lo_out     = r_res.lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenarios with literal expectations, then
// randomized traffic with emulated units, all checked against a
// transaction-level model every cycle.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst, req_mul, req_div, req_sign, flush, stall_in;
  logic [1:0]  req_mode;
  logic        mul_done, div_done;
  logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
  logic        mul_start, div_start, op_sign, busy, res_valid, res_is_div, err;
  logic [1:0]  op_mode;
  logic [31:0] hi_out, lo_out;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_mul(req_mul), .req_div(req_div),
    .req_sign(req_sign), .req_mode(req_mode), .flush(flush),
    .stall_in(stall_in), .mul_start(mul_start), .div_start(div_start),
    .op_sign(op_sign), .op_mode(op_mode), .mul_done(mul_done),
    .div_done(div_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_hi(div_hi), .div_lo(div_lo), .busy(busy), .res_valid(res_valid),
    .res_is_div(res_is_div), .hi_out(hi_out), .lo_out(lo_out), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  // Model: one outstanding operation, described by what is owed to whom.
  bit          m_known;
  bit          m_pending;
  bit          m_pend_div;
  bit          m_discard;
  bit          m_result_owed;
  bit          m_exp_mstart, m_exp_dstart;
  bit          m_sign, m_isdiv;
  logic [1:0]  m_mode;
  int          m_age;
  logic [31:0] m_hi, m_lo;

  // Values sampled in the current cycle.
  logic        s_busy, s_err, s_ms, s_ds, s_rv, s_rd, s_sign;
  logic [1:0]  s_mode;
  logic [31:0] s_hi, s_lo;

  // Emulated arithmetic units for the random phase.
  bit auto_units;
  int mul_left, div_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  function automatic int pick_latency();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 200;
    if (r == 1) return int'($urandom_range(30, 70));
    return int'($urandom_range(1, 12));
  endfunction

  task automatic clr();
    rst = 1'b1; req_mul = 1'b0; req_div = 1'b0; req_sign = 1'b0; req_mode = 2'b00;
    flush = 1'b0; stall_in = 1'b0; mul_done = 1'b0; div_done = 1'b0;
    mul_hi = '0; mul_lo = '0; div_hi = '0; div_lo = '0;
  endtask

  // Called at a negedge with inputs already driven: check, then advance one clock.
  task automatic step();
    bit new_req, hit, e_busy, e_err;
    #1;
    s_busy = busy; s_err = err; s_ms = mul_start; s_ds = div_start;
    s_rv = res_valid; s_rd = res_is_div; s_sign = op_sign; s_mode = op_mode;
    s_hi = hi_out; s_lo = lo_out;
    new_req = !m_pending && !m_result_owed && (req_mul || req_div) && !flush;
    hit     = m_pending && (m_pend_div ? div_done : mul_done);
    if (m_known) begin
      e_busy = m_pending || new_req;
      e_err  = (new_req && req_mul && req_div) || (m_pending && !hit && m_age == TO);
      chk1("busy", s_busy, e_busy);
      chk1("err", s_err, e_err);
      chk1("mul_start", s_ms, m_exp_mstart);
      chk1("div_start", s_ds, m_exp_dstart);
      chk1("res_valid", s_rv, m_result_owed);
      chk1("res_is_div", s_rd, m_isdiv);
      chk1("op_sign", s_sign, m_sign);
      chk("op_mode", 32'(s_mode), 32'(m_mode));
      chk("hi_out", s_hi, m_hi);
      chk("lo_out", s_lo, m_lo);
    end
    if (auto_units) begin
      if (s_ms) mul_left = pick_latency();
      if (s_ds) div_left = pick_latency();
    end
    @(posedge clk);
    if (!rst) begin
      m_known = 1'b1; m_pending = 1'b0; m_pend_div = 1'b0; m_discard = 1'b0;
      m_result_owed = 1'b0; m_exp_mstart = 1'b0; m_exp_dstart = 1'b0;
      m_sign = 1'b0; m_isdiv = 1'b0; m_mode = 2'b00; m_age = 0;
      m_hi = '0; m_lo = '0;
      mul_left = 0; div_left = 0;
    end else if (m_known) begin
      m_exp_mstart = 1'b0;
      m_exp_dstart = 1'b0;
      if (m_pending) begin
        if (hit) begin
          m_pending = 1'b0;
          if (!m_discard && !flush) begin
            m_result_owed = 1'b1;
            m_isdiv = m_pend_div;
            m_hi = m_pend_div ? div_hi : mul_hi;
            m_lo = m_pend_div ? div_lo : mul_lo;
          end
          m_discard = 1'b0;
        end else if (m_age == TO) begin
          m_pending = 1'b0;
          m_discard = 1'b0;
        end else begin
          if (flush) m_discard = 1'b1;
          m_age++;
        end
      end else if (m_result_owed) begin
        if (flush || !stall_in) m_result_owed = 1'b0;
      end else if (new_req) begin
        m_pending    = 1'b1;
        m_pend_div   = !req_mul;
        m_discard    = 1'b0;
        m_age        = 0;
        m_exp_mstart = req_mul;
        m_exp_dstart = !req_mul;
        m_sign       = req_sign;
        m_mode       = req_mode;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_random();
    clr();
    rst      = ($urandom_range(0, 149) != 0);
    req_mul  = ($urandom_range(0, 2) == 0);
    req_div  = ($urandom_range(0, 2) == 0);
    req_sign = 1'($urandom);
    req_mode = 2'($urandom);
    flush    = ($urandom_range(0, 11) == 0);
    stall_in = 1'($urandom);
    mul_hi = $urandom; mul_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
    if (mul_left > 0) begin mul_left--; mul_done = (mul_left == 0); end
    if (div_left > 0) begin div_left--; div_done = (div_left == 0); end
    if ($urandom_range(0, 39) == 0) mul_done = 1'b1;
    if ($urandom_range(0, 39) == 0) div_done = 1'b1;
  endtask

  initial begin
    m_known = 1'b0; m_pending = 1'b0; m_result_owed = 1'b0;
    m_exp_mstart = 1'b0; m_exp_dstart = 1'b0; m_age = 0;
    auto_units = 1'b0; mul_left = 0; div_left = 0;
    clr();
    rst = 1'b0;
    @(negedge clk);
    step();
    step();

    // Reset state, literal.
    clr();
    step();
    chk1("rst_busy", s_busy, 1'b0);
    chk1("rst_rv", s_rv, 1'b0);
    chk("rst_hi", s_hi, 32'h0);

    // Signed mult, L=4.
    for (int c = 0; c < 8; c++) begin
      clr();
      if (c == 0) begin req_mul = 1'b1; req_sign = 1'b1; end
      if (c == 5) begin mul_done = 1'b1; mul_hi = 32'hFFFF_FFFF; mul_lo = 32'hFFFF_FFFE; end
      step();
      chk1("t_mult_start", s_ms, c == 1);
      chk1("t_mult_busy", s_busy, c <= 5);
      chk1("t_mult_rv", s_rv, c == 6);
      if (c == 6) begin
        chk("t_mult_hi", s_hi, 32'hFFFF_FFFF);
        chk("t_mult_lo", s_lo, 32'hFFFF_FFFE);
        chk1("t_mult_isdiv", s_rd, 1'b0);
        chk1("t_mult_sign", s_sign, 1'b1);
      end
    end

    // Divu, L=33, result held through three stalled cycles.
    for (int c = 0; c < 40; c++) begin
      clr();
      if (c == 0) req_div = 1'b1;
      if (c == 34) begin div_done = 1'b1; div_hi = 32'h1234_5678; div_lo = 32'h9ABC_DEF0; end
      stall_in = (c >= 35 && c <= 37);
      step();
      chk1("t_divu_start", s_ds, c == 1);
      chk1("t_divu_busy", s_busy, c <= 34);
      chk1("t_divu_rv", s_rv, c >= 35 && c <= 38);
      if (c >= 35 && c <= 38) begin
        chk("t_divu_hi", s_hi, 32'h1234_5678);
        chk("t_divu_lo", s_lo, 32'h9ABC_DEF0);
        chk1("t_divu_isdiv", s_rd, 1'b1);
      end
    end

    // Flush in cycle 3 of a div, drained done at 34, new mul accepted at 35.
    for (int c = 0; c < 40; c++) begin
      clr();
      if (c == 0) req_div = 1'b1;
      if (c == 3) flush = 1'b1;
      if (c == 34) begin div_done = 1'b1; div_hi = 32'hDEAD_BEEF; div_lo = 32'hDEAD_BEEF; end
      if (c == 35) req_mul = 1'b1;
      if (c == 37) begin mul_done = 1'b1; mul_hi = 32'h1; mul_lo = 32'h2; end
      step();
      chk1("t_flush_busy", s_busy, c <= 37);
      chk1("t_flush_rv", s_rv, c == 38);
      chk1("t_flush_mstart", s_ms, c == 36);
      chk("t_flush_hi", s_hi, (c >= 38) ? 32'h1 : 32'h1234_5678);
    end

    // Both requests together: mul wins, err pulses in cycle 0.
    for (int c = 0; c < 5; c++) begin
      clr();
      if (c == 0) begin req_mul = 1'b1; req_div = 1'b1; end
      if (c == 2) begin mul_done = 1'b1; mul_hi = 32'h3; mul_lo = 32'h4; end
      step();
      chk1("t_both_err", s_err, c == 0);
      chk1("t_both_mstart", s_ms, c == 1);
      chk1("t_both_dstart", s_ds, 1'b0);
      chk1("t_both_rv", s_rv, c == 3);
    end

    // Unit never answers: timeout at wait count 64.
    for (int c = 0; c < 67; c++) begin
      clr();
      if (c == 0) req_mul = 1'b1;
      step();
      chk1("t_to_err", s_err, c == 65);
      chk1("t_to_busy", s_busy, c <= 65);
      chk("t_to_hi", s_hi, 32'h3);
    end

    // Reset during MUL_WAIT, then a late done.
    for (int c = 0; c < 5; c++) begin
      clr();
      if (c == 0) begin req_mul = 1'b1; req_sign = 1'b1; req_mode = 2'b10; end
      if (c == 2) rst = 1'b0;
      if (c == 3) begin mul_done = 1'b1; mul_hi = 32'h7; mul_lo = 32'h7; end
      step();
      if (c == 1) begin
        chk1("t_rst_sign1", s_sign, 1'b1);
        chk("t_rst_mode1", 32'(s_mode), 32'd2);
      end
      if (c >= 3) begin
        chk1("t_rst_busy", s_busy, 1'b0);
        chk1("t_rst_rv", s_rv, 1'b0);
        chk1("t_rst_sign", s_sign, 1'b0);
        chk("t_rst_mode", 32'(s_mode), 32'd0);
        chk("t_rst_hi", s_hi, 32'h0);
        chk("t_rst_lo", s_lo, 32'h0);
      end
    end

    // Randomized traffic with emulated units.
    auto_units = 1'b1;
    mul_left = 0;
    div_left = 0;
    for (int n = 0; n < 4000; n++) begin
      drive_random();
      step();
    end

    clr();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
